iob_sp_ram_be_ctrl: RTL and testbench

- Initiator/controller for the single-port byte-enable RAM: accepts word requests on a valid/ready request channel, drives the RAM port (en, we, addr, din), and captures the 1-cycle-latency read-first dout.
- Returns read data on a valid/ready response channel buffered by a small FIFO, so response backpressure never loses RAM read data.
- Sits between a CPU/DMA-side native bus and an iob_sp_ram_be instance.

---
 rtl/iob_sp_ram_be_ctrl.sv | 111 +++++++++++
 tb/tb_iob_sp_ram_be_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/iob_sp_ram_be_ctrl.sv
// Request/response controller for a single-port byte-enable RAM with 1-cycle read latency.
// Reads are returned in order through a small credit-protected response FIFO.
module iob_sp_ram_be_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  ram_en,
    output logic [DATA_W/8-1:0]   ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_din,
    input  logic [DATA_W-1:0]     ram_dout
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST_C = PTR_W'(RSP_DEPTH - 1);

    logic [DATA_W-1:0] fifo_mem_r [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  occ_r;
    logic              inflight_r;

    logic [CNT_W-1:0]  count_s;
    logic              accept_s;
    logic              rd_accept_s;
    logic              push_s;
    logic              pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST_C) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Credit accounting: an outstanding read already owns a FIFO slot.
    always_comb begin
        count_s     = occ_r + {{(CNT_W-1){1'b0}}, inflight_r};
        rsp_valid   = (occ_r != {CNT_W{1'b0}});
        pop_s       = rsp_valid && rsp_ready;
        req_ready   = !rst && ((count_s < DEPTH_C) || pop_s);
        accept_s    = req_valid && req_ready;
        rd_accept_s = accept_s && (req_wstrb == {STRB_W{1'b0}});
        push_s      = inflight_r;
        if (rsp_valid) begin
            rsp_rdata = fifo_mem_r[rd_ptr_r];
        end else begin
            rsp_rdata = {DATA_W{1'b0}};
        end
    end

    // RAM port is a straight pass-through of the accepted request.
    always_comb begin
        ram_en   = accept_s;
        ram_addr = req_addr;
        ram_din  = req_wdata;
        if (accept_s) begin
            ram_we = req_wstrb;
        end else begin
            ram_we = {STRB_W{1'b0}};
        end
    end

    // FIFO pointers, occupancy and the in-flight read flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            occ_r      <= {CNT_W{1'b0}};
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_accept_s;
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   occ_r <= occ_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: occ_r <= occ_r;
            endcase
        end
    end

    // FIFO storage captures RAM read data the cycle after a read is accepted.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fifo_mem_r[wr_ptr_r] <= ram_dout;
        end
    end

endmodule

// File: tb/tb_iob_sp_ram_be_ctrl.sv
// Scoreboard bench for iob_sp_ram_be_ctrl with a behavioural read-first byte-enable RAM.
module tb_iob_sp_ram_be_ctrl;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wstrb;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          ram_en;
    logic [SW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    logic [DW-1:0] ram_mem [0:(1<<AW)-1];

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        bit            lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   accepted = 0;

    iob_sp_ram_be_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RSP_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first RAM with per-byte write enables
    always @(posedge clk) begin
        if (ram_en) begin
            ram_dout <= ram_mem[ram_addr];
            for (int b = 0; b < SW; b++) begin
                if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end
        end
    end

    task automatic chk(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Present one request (entered at a negedge) and wait for acceptance.
    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input logic [DW-1:0] exp, input bit want_rsp, input bit lat);
        int n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(req_ready, "req_accept_timeout", {31'd0, req_ready}, 32'd1);
        if (req_ready) begin
            accepted++;
            if (s != 4'h0) chk(ram_en && ram_we == s, "ram_we_on_write", {28'd0, ram_we}, {28'd0, s});
            else if (want_rsp) exp_q.push_back('{exp, cyc, lat});
        end
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_wstrb = 4'h0;
    endtask

    // Monitor: pop the scoreboard on every response handshake
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data;
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst) begin
            if (prev_hold) chk(rsp_valid && rsp_rdata == prev_data, "rsp_hold", rsp_rdata, prev_data);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_rsp", rsp_rdata, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(rsp_rdata == e.data, "rsp_data", rsp_rdata, e.data);
                    if (e.lat) chk(cyc - e.cyc == 2, "rsp_latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
        end
        prev_hold = rsp_valid && !rsp_ready && !rst;
        prev_data = rsp_rdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=%0d expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = 32'd0;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 10'd1;
        req_wdata = 32'h1234_5678;
        req_wstrb = 4'hF;

        repeat (2) begin
            @(negedge clk);
            #1;
            chk(!req_ready, "rst_req_ready", {31'd0, req_ready}, 32'd0);
            chk(!ram_en, "rst_ram_en", {31'd0, ram_en}, 32'd0);
            chk(ram_we == 4'h0, "rst_ram_we", {28'd0, ram_we}, 32'd0);
            chk(!rsp_valid && rsp_rdata == 32'd0, "rst_rsp", rsp_rdata, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        chk(req_ready, "ready_after_rst", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // Full write then read-back
        issue(10'd5, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 1'b0);
        issue(10'd5, 32'd0, 4'h0, 32'hDEAD_BEEF, 1'b1, 1'b1);
        idle();
        repeat (4) @(negedge clk);

        // Partial write of byte 1
        issue(10'd5, 32'h0000_AA00, 4'h2, 32'd0, 1'b0, 1'b0);
        issue(10'd5, 32'd0, 4'h0, 32'hDEAD_AAEF, 1'b1, 1'b1);
        idle();
        repeat (4) @(negedge clk);

        // Preload addrs 0..7 with value = addr
        for (int i = 0; i < 8; i++) issue(AW'(i), 32'(i), 4'hF, 32'd0, 1'b0, 1'b0);
        idle();
        @(negedge clk);

        // Back-to-back reads, no backpressure
        start = cyc;
        for (int i = 0; i < 8; i++) issue(AW'(i), 32'd0, 4'h0, 32'(i), 1'b1, 1'b1);
        chk(cyc - start == 8, "one_accept_per_cycle", 32'(cyc - start), 32'd8);
        idle();
        repeat (4) @(negedge clk);

        // Same stream under backpressure
        rsp_ready = 1'b0;
        accepted  = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) issue(AW'(i), 32'd0, 4'h0, 32'(i), 1'b1, 1'b0);
                idle();
            end
            begin
                repeat (6) @(negedge clk);
                #1;
                chk(accepted == 2, "bp_accepted", 32'(accepted), 32'd2);
                chk(!req_ready, "bp_req_ready", {31'd0, req_ready}, 32'd0);
                chk(rsp_valid && rsp_rdata == 32'd0, "bp_rsp_rdata", rsp_rdata, 32'd0);
                @(negedge clk);
                rsp_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        chk(exp_q.size() == 0, "bp_drained", 32'(exp_q.size()), 32'd0);

        // Reset right after a read is accepted drops it
        issue(10'd7, 32'd0, 4'h0, 32'd0, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk(!rsp_valid, "rst_drop_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        @(negedge clk);
        issue(10'd3, 32'd0, 4'h0, 32'd3, 1'b1, 1'b1);
        idle();
        repeat (4) @(negedge clk);
        chk(exp_q.size() == 0, "final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
